// File: rtl/scenario_sequencer.sv
// -----------------------------------------------------------------------------
// scenario_sequencer
//
// Purpose:
//   Command generator for the two bus masters. A start pulse in IDLE latches a
//   5-bit scenario code and decodes it into per-master commands. Both masters
//   are launched in the same cycle. The block then waits for each enabled
//   master's done and reports completion, or times out.
//
// Handshake:
//   start is level-sampled in IDLE only. A transaction is accepted on the
//   rising edge where state is IDLE and start is 1. m1_start and m2_start are
//   one-cycle pulses in LAUNCH. m1_done and m2_done are pulses that are
//   sampled in WAIT only. done is a one-cycle pulse in DONE.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   start, state_in       launch request and scenario code
//   m1_done, m2_done      per-master completion pulses
//   m*_start              per-master launch pulse (enabled masters only)
//   m*_write/slave        1 = write / 1 = slave 2
//   m*_addr, m*_wdata     fixed address and data from parameters
//   burst_len             BURST_LEN while a command is held, else 0
//   busy                  high from LAUNCH through DONE
//   done                  completion pulse
//   timeout               sticky abort flag; cleared by the next accepted start
//   o_dbg_state           current FSM state (0 IDLE, 1 LAUNCH, 2 WAIT, 3 DONE)
// -----------------------------------------------------------------------------
module scenario_sequencer #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 8,
  parameter int BURST_LEN      = 16,
  parameter int M1_ADDR        = 1365,
  parameter int M1_DATA        = 170,
  parameter int M2_ADDR        = 682,
  parameter int M2_DATA        = 85,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4:0]            state_in,
  input  logic                  m1_done,
  input  logic                  m2_done,
  output logic                  m1_start,
  output logic                  m2_start,
  output logic                  m1_write,
  output logic                  m2_write,
  output logic                  m1_slave,
  output logic                  m2_slave,
  output logic [ADDR_WIDTH-1:0] m1_addr,
  output logic [ADDR_WIDTH-1:0] m2_addr,
  output logic [DATA_WIDTH-1:0] m1_wdata,
  output logic [DATA_WIDTH-1:0] m2_wdata,
  output logic [7:0]            burst_len,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // The abort fires at the end of WAIT cycle number TIMEOUT_CYCLES.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t r_state;
  state_t w_next;

  logic                  r_m1_en, r_m2_en;
  logic                  r_m1_write, r_m2_write;
  logic                  r_m1_slave, r_m2_slave;
  logic [ADDR_WIDTH-1:0] r_m1_addr, r_m2_addr;
  logic [DATA_WIDTH-1:0] r_m1_wdata, r_m2_wdata;
  logic [7:0]            r_burst_len;
  logic                  r_m1_flag, r_m2_flag;
  logic [15:0]           r_cnt;
  logic                  r_timeout;

  logic w_m1_en, w_m2_en, w_m1_wr, w_m2_wr, w_m1_sl, w_m2_sl;
  logic w_accept, w_all_done, w_expire;

  // Scenario decode. Codes that are not listed leave both masters disabled.
  always_comb begin
    w_m1_en = 1'b0; w_m1_wr = 1'b0; w_m1_sl = 1'b0;
    w_m2_en = 1'b0; w_m2_wr = 1'b0; w_m2_sl = 1'b0;
    case (state_in)
      5'd1: begin w_m1_en = 1'b1; w_m1_wr = 1'b1; w_m1_sl = 1'b1; end
      5'd2: begin w_m1_en = 1'b1; w_m1_sl = 1'b1;
                  w_m2_en = 1'b1; w_m2_wr = 1'b1; w_m2_sl = 1'b1; end
      5'd3: begin w_m1_en = 1'b1; w_m1_sl = 1'b1;
                  w_m2_en = 1'b1; w_m2_wr = 1'b1; end
      5'd4: begin w_m1_en = 1'b1; w_m1_sl = 1'b1;
                  w_m2_en = 1'b1; w_m2_sl = 1'b1; end
      5'd5: begin w_m1_en = 1'b1; w_m1_wr = 1'b1; w_m1_sl = 1'b1;
                  w_m2_en = 1'b1; w_m2_wr = 1'b1; w_m2_sl = 1'b1; end
      5'd6: begin w_m1_en = 1'b1;
                  w_m2_en = 1'b1; w_m2_sl = 1'b1; end
      5'd7: begin w_m1_en = 1'b1; w_m1_wr = 1'b1;
                  w_m2_en = 1'b1; end
      5'd8: begin w_m1_en = 1'b1;
                  w_m2_en = 1'b1; w_m2_wr = 1'b1; end
      5'd9: begin w_m1_en = 1'b1; w_m1_wr = 1'b1; w_m1_sl = 1'b1;
                  w_m2_en = 1'b1; w_m2_wr = 1'b1; end
      default: ;
    endcase
  end

  assign w_accept   = (r_state == S_IDLE) && start;
  // The registered flags decide completion. A done sampled at edge K
  // therefore produces the done pulse two cycles after the done input.
  assign w_all_done = r_m1_flag && r_m2_flag;
  assign w_expire   = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_LAUNCH;
      S_LAUNCH: w_next = (r_m1_en || r_m2_en) ? S_WAIT : S_DONE;
      S_WAIT:   if (w_all_done || w_expire) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m1_en     <= 1'b0;
      r_m2_en     <= 1'b0;
      r_m1_write  <= 1'b0;
      r_m2_write  <= 1'b0;
      r_m1_slave  <= 1'b0;
      r_m2_slave  <= 1'b0;
      r_m1_addr   <= '0;
      r_m2_addr   <= '0;
      r_m1_wdata  <= '0;
      r_m2_wdata  <= '0;
      r_burst_len <= '0;
      r_m1_flag   <= 1'b0;
      r_m2_flag   <= 1'b0;
      r_cnt       <= '0;
      r_timeout   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_m1_en     <= w_m1_en;
        r_m2_en     <= w_m2_en;
        r_m1_write  <= w_m1_wr;
        r_m2_write  <= w_m2_wr;
        r_m1_slave  <= w_m1_sl;
        r_m2_slave  <= w_m2_sl;
        r_m1_addr   <= ADDR_WIDTH'(M1_ADDR);
        r_m2_addr   <= ADDR_WIDTH'(M2_ADDR);
        r_m1_wdata  <= DATA_WIDTH'(M1_DATA);
        r_m2_wdata  <= DATA_WIDTH'(M2_DATA);
        r_burst_len <= 8'(BURST_LEN);
        // A disabled master counts as already finished.
        r_m1_flag   <= ~w_m1_en;
        r_m2_flag   <= ~w_m2_en;
        r_cnt       <= '0;
        r_timeout   <= 1'b0;
      end
      if (r_state == S_WAIT) begin
        if (m1_done) r_m1_flag <= 1'b1;
        if (m2_done) r_m2_flag <= 1'b1;
        if (!w_all_done) begin
          if (w_expire) r_timeout <= 1'b1;
          else          r_cnt     <= r_cnt + 16'd1;
        end
      end
      if (r_state == S_DONE) begin
        r_m1_en     <= 1'b0;
        r_m2_en     <= 1'b0;
        r_m1_write  <= 1'b0;
        r_m2_write  <= 1'b0;
        r_m1_slave  <= 1'b0;
        r_m2_slave  <= 1'b0;
        r_m1_addr   <= '0;
        r_m2_addr   <= '0;
        r_m1_wdata  <= '0;
        r_m2_wdata  <= '0;
        r_burst_len <= '0;
        r_m1_flag   <= 1'b0;
        r_m2_flag   <= 1'b0;
        r_cnt       <= '0;
      end
    end
  end

  assign m1_start    = (r_state == S_LAUNCH) && r_m1_en;
  assign m2_start    = (r_state == S_LAUNCH) && r_m2_en;
  assign m1_write    = r_m1_write;
  assign m2_write    = r_m2_write;
  assign m1_slave    = r_m1_slave;
  assign m2_slave    = r_m2_slave;
  assign m1_addr     = r_m1_addr;
  assign m2_addr     = r_m2_addr;
  assign m1_wdata    = r_m1_wdata;
  assign m2_wdata    = r_m2_wdata;
  assign burst_len   = r_burst_len;
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign timeout     = r_timeout;
  assign o_dbg_state = r_state;

endmodule
